// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM states and datapath widths.
package bcd_pkg;

    localparam int DIGIT_W  = 4;
    localparam int N_DIGITS = 3;
    localparam int BIN_W    = 8;
    localparam int BCD_W    = DIGIT_W * N_DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_2_binary_sub3.sv
// Per-nibble correction step of the reverse double-dabble: the inverse of the classic add3 cell.
module sub3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_nib,
    output logic [DIGIT_W-1:0] o_nib
);

    assign o_nib = (i_nib >= 4'd8) ? (i_nib - 4'd3) : i_nib;

endmodule

// File: rtl/bcd_2_binary.sv
// Three-digit BCD to 8-bit binary converter using shift-right / subtract-3 iterations.
module bcd_2_binary
    import bcd_pkg::*;
#(
    parameter int N_SHIFT = 8
)
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [3:0]       i_hunds,
    input  logic [3:0]       i_tens,
    input  logic [3:0]       i_units,
    output logic [BIN_W-1:0] o_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error
);

    localparam logic [3:0] LAST_COUNT = 4'(N_SHIFT - 1);

    state_t                   r_state;
    state_t                   w_nextState;
    logic [BCD_W-1:0]         r_bcd;
    logic [BIN_W-1:0]         r_bin;
    logic [3:0]               r_count;
    logic [BIN_W-1:0]         r_data;
    logic                     r_error;
    logic                     w_digitsOk;
    logic                     w_lastShift;
    logic [BCD_W+BIN_W-1:0]   w_shifted;
    logic [BCD_W-1:0]         w_bcdNext;

    assign w_digitsOk  = (i_hunds <= 4'd9) && (i_tens <= 4'd9) && (i_units <= 4'd9);
    assign w_lastShift = (r_count == LAST_COUNT);
    assign w_shifted   = {r_bcd, r_bin} >> 1;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_sub3
        sub3 u_sub3 (
            .i_nib (w_shifted[BIN_W + g*DIGIT_W +: DIGIT_W]),
            .o_nib (w_bcdNext[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        o_busy      = (r_state != IDLE);
        o_done      = (r_state == DONE);
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = w_digitsOk ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (w_lastShift) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Any BCD residue after the final shift means the decimal value exceeded 255.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bcd   <= '0;
            r_bin   <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_data <= '0;
                        if (w_digitsOk) begin
                            r_bcd   <= {i_hunds, i_tens, i_units};
                            r_bin   <= '0;
                            r_count <= '0;
                            r_error <= 1'b0;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    r_bcd   <= w_bcdNext;
                    r_bin   <= w_shifted[BIN_W-1:0];
                    r_count <= r_count + 4'd1;
                    if (w_lastShift) begin
                        if (w_bcdNext != '0) begin
                            r_data  <= '0;
                            r_error <= 1'b1;
                        end else begin
                            r_data  <= w_shifted[BIN_W-1:0];
                            r_error <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data  = r_data;
    assign o_error = r_error;

endmodule

// File: tb/tb_bcd_2_binary.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor checks every o_done pulse.
module tb_bcd_2_binary;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         doneEdge;
    } exp_t;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [3:0] i_hunds = '0;
    logic [3:0] i_tens = '0;
    logic [3:0] i_units = '0;
    logic [7:0] o_data;
    logic       o_busy;
    logic       o_done;
    logic       o_error;

    int   errors = 0;
    int   checks = 0;
    int   edgeCount = 0;
    exp_t expQ[$];
    exp_t monEntry;

    bcd_2_binary #(.N_SHIFT(8)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_hunds (i_hunds),
        .i_tens  (i_tens),
        .i_units (i_units),
        .o_data  (o_data),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_error (o_error)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) edgeCount++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edgeCount);
        end
    endtask

    // Reference: plain decimal arithmetic on the digits, nothing about shifting.
    function automatic exp_t refModel(input int h, input int t, input int u, input int acceptEdge);
        exp_t e;
        int   v;
        if (h > 9 || t > 9 || u > 9) begin
            e.data = 8'h00; e.err = 1'b1; e.doneEdge = acceptEdge;
        end else begin
            v = h * 100 + t * 10 + u;
            e.data     = (v > 255) ? 8'h00 : 8'(v);
            e.err      = (v > 255);
            e.doneEdge = acceptEdge + 8;
        end
        return e;
    endfunction

    task automatic waitIdle();
        int n = 0;
        @(negedge i_clk);
        while (o_busy && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (o_busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: o_busy=%0b, expected 0", o_busy);
        end
    endtask

    // Issues one start pulse from IDLE, then scrambles the digits while the conversion runs.
    task automatic applyStimulus(input int h, input int t, input int u);
        waitIdle();
        i_hunds = 4'(h);
        i_tens  = 4'(t);
        i_units = 4'(u);
        i_start = 1'b1;
        expQ.push_back(refModel(h, t, u, edgeCount + 1));
        @(posedge i_clk);
        #1;
        checkOutput("busy_after_start", int'(o_busy), 1);
        @(negedge i_clk);
        i_start = 1'b0;
        i_hunds = 4'($urandom_range(0, 15));
        i_tens  = 4'($urandom_range(0, 15));
        i_units = 4'($urandom_range(0, 15));
    endtask

    always @(negedge i_clk) begin
        if (i_rst_n && o_done) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: o_done=1 with no conversion outstanding, data=%0h", o_data);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("o_data", int'(o_data), int'(monEntry.data));
                checkOutput("o_error", int'(o_error), int'(monEntry.err));
                checkOutput("done_edge", edgeCount, monEntry.doneEdge);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int v;
        int n;

        repeat (3) @(negedge i_clk);
        checkOutput("reset_data", int'(o_data), 0);
        checkOutput("reset_busy", int'(o_busy), 0);
        checkOutput("reset_done", int'(o_done), 0);
        checkOutput("reset_error", int'(o_error), 0);
        i_rst_n = 1'b1;

        applyStimulus(2, 5, 5);
        applyStimulus(1, 2, 8);
        applyStimulus(0, 0, 0);
        applyStimulus(2, 5, 6);
        applyStimulus(0, 10, 3);

        // Abort 1,0,0 between edges k+3 and k+4; the held error flag from 0,A,3 must clear.
        waitIdle();
        i_hunds = 4'd1; i_tens = 4'd0; i_units = 4'd0;
        i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        repeat (3) @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", int'(o_busy), 0);
        checkOutput("abort_done", int'(o_done), 0);
        checkOutput("abort_data", int'(o_data), 0);
        checkOutput("abort_error", int'(o_error), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) begin
            @(negedge i_clk);
            checkOutput("idle_after_abort", int'(o_busy), 0);
        end
        applyStimulus(0, 9, 9);

        for (int i = 0; i < 40; i++) begin
            applyStimulus($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11));
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
        end

        // Back-to-back sweep with i_start held: one accept every 10 edges.
        waitIdle();
        i_start = 1'b1;
        for (int s = 0; s < 1000; s++) begin
            i_hunds = 4'(s / 100);
            i_tens  = 4'((s / 10) % 10);
            i_units = 4'(s % 10);
            checkOutput("sweep_idle", int'(o_busy), 0);
            expQ.push_back(refModel(s / 100, (s / 10) % 10, s % 10, edgeCount + 1));
            @(posedge i_clk);
            #1;
            if (s == 999) i_start = 1'b0;
            repeat (10) @(negedge i_clk);
        end

        n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        v = expQ.size();
        checkOutput("queue_drained", v, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
